// File: rtl/pencoder_scan.sv
// Priority-encoder scanner: accepts a request vector and emits the index of
// every set bit, one beat per handshake, in LSB-first or MSB-first order.
module pencoder_scan #(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b1,
    localparam int IDXW     = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in_vec,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [IDXW-1:0]   out_idx,
    output logic              out_none,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDXW:0]     out_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]       state_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [IDXW:0]    cnt_reg;
    logic             none_reg;
    // Keeps in_ready low until the first clock edge after reset release.
    logic             init_done_reg;

    logic [IDXW-1:0]  idx_sel;
    logic [IDXW:0]    cnt_calc;
    logic [WIDTH-1:0] mask_minus_one;
    logic             mask_single;
    logic [WIDTH-1:0] sel_onehot;

    always_comb begin
        idx_sel = '0;
        if (LSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (mask_reg[i]) idx_sel = IDXW'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (mask_reg[i]) idx_sel = IDXW'(i);
            end
        end
    end

    always_comb begin
        cnt_calc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_calc = cnt_calc + (IDXW + 1)'(in_vec[i]);
        end
    end

    assign mask_minus_one = mask_reg - WIDTH'(1);
    assign mask_single    = (mask_reg != '0) && ((mask_reg & mask_minus_one) == '0);
    assign sel_onehot     = WIDTH'(1) << idx_sel;

    assign in_ready  = (state_reg == IDLE) && init_done_reg;
    assign out_valid = (state_reg == SCAN);
    assign out_idx   = idx_sel;
    assign out_none  = none_reg;
    assign out_last  = mask_single || none_reg;
    assign out_cnt   = cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mask_reg      <= '0;
            cnt_reg       <= '0;
            none_reg      <= 1'b0;
            init_done_reg <= 1'b0;
        end else begin
            init_done_reg <= 1'b1;
            if (flush) begin
                state_reg <= IDLE;
                mask_reg  <= '0;
                cnt_reg   <= '0;
                none_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (in_valid && in_ready) begin
                            mask_reg  <= in_vec;
                            cnt_reg   <= cnt_calc;
                            none_reg  <= (in_vec == '0);
                            state_reg <= SCAN;
                        end
                    end
                    default: begin
                        if (out_ready) begin
                            if (out_last) begin
                                state_reg <= IDLE;
                                mask_reg  <= '0;
                                cnt_reg   <= '0;
                                none_reg  <= 1'b0;
                            end else begin
                                mask_reg <= mask_reg & ~sel_onehot;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pencoder_scan.sv
// Directed bench: LSB-first and MSB-first instances share stimulus; table of
// vectors plus stall, flush and mid-scan reset sequences.
module tb_pencoder_scan;

    localparam int WIDTH = 32;
    localparam int IDXW  = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in_vec = '0;
    logic             in_valid = 1'b0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;

    logic             in_ready, out_none, out_last, out_valid;
    logic [IDXW-1:0]  out_idx;
    logic [IDXW:0]    out_cnt;
    logic             m_in_ready, m_out_none, m_out_last, m_out_valid;
    logic [IDXW-1:0]  m_out_idx;
    logic [IDXW:0]    m_out_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pencoder_scan #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_idx(out_idx),
        .out_none(out_none), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_cnt(out_cnt)
    );

    pencoder_scan #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
        .in_ready(m_in_ready), .flush(flush), .out_idx(m_out_idx),
        .out_none(m_out_none), .out_last(m_out_last), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_cnt(m_out_cnt)
    );

    typedef struct {
        logic [31:0] vec;
        int          cnt;
        int          first_lsb;
        int          final_lsb;
        int          first_msb;
    } vec_rec_t;

    vec_rec_t table_v[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic accept(input logic [31:0] vec);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        in_vec   = vec;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("first_beat_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic run_vec(input vec_rec_t r);
        int beats, prev_l, prev_m, first_l, last_l, first_m;
        beats = 0; prev_l = -1; prev_m = WIDTH; first_l = -1; last_l = -1; first_m = -1;
        out_ready = 1'b1;
        accept(r.vec);
        while (out_valid && beats < 70) begin
            if (beats == 0) begin
                first_l = int'(out_idx);
                first_m = int'(m_out_idx);
            end
            last_l = int'(out_idx);
            if (r.vec == 0) begin
                chk("zero_none", 64'(out_none), 64'd1);
                chk("zero_idx", 64'(out_idx), 64'd0);
            end else begin
                chk("lsb_order", 64'(int'(out_idx) > prev_l && r.vec[out_idx]), 64'd1);
                chk("msb_order", 64'(int'(m_out_idx) < prev_m && r.vec[m_out_idx]), 64'd1);
            end
            chk("beat_last", 64'(out_last), 64'(beats == ((r.cnt == 0) ? 0 : r.cnt - 1)));
            chk("beat_cnt", 64'(out_cnt), 64'(r.cnt));
            chk("msb_valid", 64'(m_out_valid), 64'd1);
            prev_l = int'(out_idx);
            prev_m = int'(m_out_idx);
            beats++;
            @(negedge clk);
        end
        chk("beats", 64'(beats), 64'((r.cnt == 0) ? 1 : r.cnt));
        chk("first_lsb", 64'(first_l), 64'(r.first_lsb));
        chk("final_lsb", 64'(last_l), 64'(r.final_lsb));
        chk("first_msb", 64'(first_m), 64'(r.first_msb));
        chk("ready_after", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int expd, consumed, guard;
        table_v[0] = '{32'h8000_0011, 3, 0, 31, 31};
        table_v[1] = '{32'h0000_0000, 0, 0, 0, 0};
        table_v[2] = '{32'h0000_0106, 3, 1, 8, 8};
        table_v[3] = '{32'h0000_0001, 1, 0, 0, 0};
        table_v[4] = '{32'hFFFF_FFFF, 32, 0, 31, 31};
        table_v[5] = '{32'h1234_5678, 13, 3, 28, 28};
        table_v[6] = '{32'h8000_0000, 1, 31, 31, 31};

        // Reset state
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_cnt", 64'(out_cnt), 64'd0);
        chk("rst_out_none", 64'(out_none), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 7; i++) run_vec(table_v[i]);

        // All-ones with out_ready toggling and in_valid held high (ignored)
        accept(32'hFFFF_FFFF);
        in_valid = 1'b1;
        in_vec   = 32'h0;
        expd = 0; consumed = 0; guard = 0;
        while (out_valid && guard < 200) begin
            chk("stall_idx", 64'(out_idx), 64'(expd));
            chk("stall_last", 64'(out_last), 64'(expd == 31));
            chk("stall_cnt", 64'(out_cnt), 64'd32);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            out_ready = (guard % 2 == 0);
            if (out_ready) begin
                expd++;
                consumed++;
            end
            guard++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("stall_beats", 64'(consumed), 64'd32);

        // Flush after the second beat of 0xFF
        accept(32'h0000_00FF);
        out_ready = 1'b1;
        chk("flush_b0", 64'(out_idx), 64'd0);
        @(negedge clk);
        chk("flush_b1", 64'(out_idx), 64'd1);
        @(negedge clk);
        chk("flush_b2_shown", 64'(out_idx), 64'd2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("flush_no_beats", 64'(out_valid), 64'd0);
        run_vec(table_v[3]);

        // Reset pulse mid-scan
        accept(32'hF000_0000);
        chk("rs_idx", 64'(out_idx), 64'd28);
        chk("rs_cnt", 64'(out_cnt), 64'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_valid", 64'(out_valid), 64'd0);
        chk("rs_ready", 64'(in_ready), 64'd0);
        chk("rs_out_cnt", 64'(out_cnt), 64'd0);
        chk("rs_out_idx", 64'(out_idx), 64'd0);
        chk("rs_out_last", 64'(out_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rs_release_ready", 64'(in_ready), 64'd1);
        chk("rs_release_valid", 64'(out_valid), 64'd0);
        chk("rs_release_none", 64'(out_none), 64'd0);
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pencoder_scan.md
PENCODER_SCAN -- requirements
Module: pencoder_scan

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning request vector width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter LSB_FIRST, default 1, meaning scan order: 1 = lowest set index first, 0 = highest set index first.
REQ-003 SHALL define local IDXW = log2(WIDTH), meaning index width (5 at default).
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-006 SHALL have port in_vec, input, WIDTH bits, meaning request vector to scan.
REQ-007 SHALL have port in_valid, input, 1 bit, meaning in_vec is presented.
REQ-008 SHALL have port in_ready, output, 1 bit, meaning the block accepts a vector this cycle.
REQ-009 SHALL have port flush, input, 1 bit, meaning abandon the current scan synchronously.
REQ-010 SHALL have port out_idx, output, IDXW bits, meaning index of the current selected set bit.
REQ-011 SHALL have port out_none, output, 1 bit, meaning the accepted vector was all zero.
REQ-012 SHALL have port out_last, output, 1 bit, meaning the current beat is the final one for this vector.
REQ-013 SHALL have port out_valid, output, 1 bit, meaning out_idx/out_none/out_last are valid.
REQ-014 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the current beat.
REQ-015 SHALL have port out_cnt, output, IDXW+1 bits, meaning population count of the accepted vector, held for the whole scan.

Function
REQ-016 SHALL implement two states: IDLE and SCAN.
REQ-017 SHALL drive in_ready = 1 only in IDLE; SHALL drive out_valid = 1 only in SCAN.
REQ-018 SHALL, on in_valid & in_ready, capture in_vec into a WIDTH-bit mask register, compute out_cnt, and enter SCAN; first out_valid appears exactly one cycle after the accepting edge.
REQ-019 SHALL derive out_idx combinationally from the mask register: lowest set index when LSB_FIRST=1, highest when LSB_FIRST=0.
REQ-020 SHALL assert out_last when the mask holds exactly one set bit, or when out_none = 1.
REQ-021 SHALL, for an all-zero captured vector, present a single beat with out_none = 1, out_idx = 0, out_last = 1, out_cnt = 0.
REQ-022 SHALL, on out_valid & out_ready with out_last = 0, clear the bit at out_idx in the mask and remain in SCAN; the next index appears in the following cycle.
REQ-023 SHALL, on out_valid & out_ready with out_last = 1, clear the mask and return to IDLE; in_ready rises the following cycle.
REQ-024 SHALL hold out_idx, out_none, out_last and out_cnt stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL, when flush = 1, clear the mask and return to IDLE at the next edge regardless of state or handshakes; flush takes priority over both handshakes in the same cycle.
REQ-026 SHALL produce exactly out_cnt beats per nonzero vector (one beat for zero), with strictly increasing indices (LSB_FIRST=1) or strictly decreasing indices (LSB_FIRST=0).
REQ-027 SHALL ignore in_valid and in_vec while in SCAN.
REQ-028 SHALL sustain one beat per cycle when out_ready is held at 1.

Reset
REQ-029 SHALL, while rst_n = 0, force state IDLE, mask = 0, out_cnt = 0, out_valid = 0, in_ready = 0, out_none = 0; out_idx = 0, out_last = 0 follow from mask = 0.
REQ-030 SHALL drive in_ready = 1 from the first rising clk edge after rst_n deasserts.
REQ-031 SHALL abort any scan in progress when rst_n asserts, with no further beats for that vector.

Verification (WIDTH=32, LSB_FIRST=1 unless stated)
REQ-032 SHALL cover: in_vec = 0x8000_0011, out_ready = 1 -> beats idx 0, 4, 31 on three consecutive cycles, out_last only on 31, out_cnt = 3, in_ready high the next cycle.
REQ-033 SHALL cover: in_vec = 0x0000_0000 -> one beat with out_none = 1, out_idx = 0, out_last = 1, out_cnt = 0.
REQ-034 SHALL cover: LSB_FIRST=0, in_vec = 0x0000_0106 -> beats 8, 2, 1 in that order.
REQ-035 SHALL cover: in_vec = 0xFFFF_FFFF with out_ready toggling 1,0,1,0 -> 32 beats, idx 0..31, outputs stable during stalls, out_cnt = 32.
REQ-036 SHALL cover: flush asserted after the second beat of 0x0000_00FF -> IDLE next cycle, no further beats, next vector 0x1 yields a single beat idx 0.
REQ-037 SHALL cover: rst_n pulsed low during the scan of 0xF000_0000 -> out_valid = 0 immediately, in_ready = 1 after release, all registers 0.
